router_rd_sched: RTL and testbench
==================================

# router_rd_sched

Read-side scheduler for the 1x3 router. It watches the three output ports (valid flag plus data byte per port) and drives their per-port read enables. It drains one whole packet at a time from the chosen port, using packet-granular round-robin arbitration. The bytes go out on a single byte-wide valid/ready stream, with start-of-packet and end-of-packet markers.

## Interface
Parameters:
- STALL_LIMIT, 24: mid-packet cycles with the granted port's valid flag low before the packet is aborted. Must stay below the router's 30-cycle output soft-reset timeout.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- vld_out_0/1/2  in  1 each  router output port holds data
- data_out_0/1/2  in  8 each  router output port data; valid one cycle after the matching read_enb
- read_enb_0/1/2  out  1 each  router port read enable; combinational from registered state and credit
- m_data  out  8  egress byte
- m_valid  out  1  egress byte valid
- m_ready  in  1  egress accept
- m_sop  out  1  qualifies the header byte
- m_eop  out  1  qualifies the parity byte
- grant  out  2  port currently being drained; 3 = none
- abort  out  1  one-cycle pulse when a packet is abandoned
- par_err  out  1  one-cycle pulse on parity mismatch; exists only with the configuration macro

## Operation
- Packet format (fixed): header byte = {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte. len = 0 is legal (2-byte packet).
- FSM states: ARB, HDR, LEN, BODY, FLUSH.
- ARB: pick the first port with vld_out high, starting from rr_ptr and wrapping. If one is found, load grant and go to HDR. If none, stay in ARB with grant = 3.
- HDR: assert read_enb[grant] for one cycle (credit permitting), then go to LEN.
- LEN: wait for the header byte to arrive. Load remain = len + 1, then go to BODY.
- BODY: assert read_enb[grant] whenever all of the following hold: vld_out[grant] is high, remain > 0, and credit is available. Decrement remain on each read. When remain reaches 0, go to FLUSH.
- FLUSH: wait until the byte tagged eop has been accepted downstream. Then set rr_ptr = grant + 1 (mod 3), set grant = 3, and go to ARB.
- Credit: read only if (skid occupancy − pop this cycle + reads in flight) < 2. Reads in flight is at most 1.
- Skid tagging: the header byte enters tagged sop. The final byte of the packet enters tagged eop.
- Stall: in BODY with vld_out[grant] low, count cycles. When the count reaches STALL_LIMIT:
  - pulse abort;
  - bytes already in the skid still drain, but the eop tag is not produced;
  - reset rr_ptr as in FLUSH and return to ARB.
- Read-enable rule: read_enb for a port whose vld_out is low is never asserted. Only one read_enb is ever high in any cycle.
- Reset mid-packet: all state clears immediately. Any partial packet is lost; the router's own timeout handles the stale data.

## Timing
- Reset values: read_enb_* = 0, m_valid = 0, m_sop = 0, m_eop = 0, abort = 0, par_err = 0, grant = 3, rr_ptr = 0, state = ARB, skid empty.
- vld_out_x rises in cycle t while in ARB:
  - read_enb_x is high at t+1;
  - the header is captured at the end of t+2;
  - m_valid and m_sop are high at t+3.
- Each packet costs one LEN bubble. With m_ready held high, throughput is then 1 byte per cycle.
- After the eop byte is accepted, arbitration restarts the next cycle. The gap between packets is at most 3 cycles.
- m_data, m_sop and m_eop hold stable while m_valid is high and m_ready is low.

## Configuration
- ROUTER_RD_PARITY_EN defined:
  - XOR the header and payload bytes of each packet;
  - compare the result with the parity byte when that byte enters the skid;
  - pulse par_err on mismatch, in the same cycle the parity byte is presented with m_valid.
  - Data always passes through unchanged.
- Undefined: the par_err port and the XOR logic are absent.

## Structure
- Shared package router_pkg holds:
  - the state enum;
  - the GRANT_NONE = 2'd3 constant;
  - header field slices: LEN_MSB = 7, LEN_LSB = 2, ADDR_MSB = 1.
- Sub-module router_skid_buf: a 2-entry 10-bit buffer ({sop, eop, data}) with push, pop, count and valid/ready on the output. The top level handles arbitration, counters and parity.

## Test plan
- Packet with len = 3 on port 1:
  - read_enb_1 is high for exactly 5 cycles;
  - m_data carries header 0x0D, 3 payload bytes, then parity;
  - m_sop is set on the header only and m_eop on the parity byte only.
- vld_out_0 and vld_out_2 rise in the same cycle, each with a len = 2 packet: port 0 is drained fully, then port 2. If port 0 then has another packet, it is served next.
- m_ready held low for 6 cycles mid-packet:
  - no read_enb while the skid holds 2 bytes;
  - all 2 + len bytes arrive in order with no duplicates.
- Packet with len = 0 on port 2: exactly 2 bytes out; m_sop and m_eop fall on separate bytes.
- vld_out_0 drops after 1 payload byte and stays low for STALL_LIMIT cycles:
  - abort pulses once;
  - no eop is emitted;
  - grant returns to 3;
  - the next packet is served normally.
- With ROUTER_RD_PARITY_EN, corrupt the parity byte of a len = 4 packet: par_err pulses alongside the eop byte. A correct packet produces no pulse.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router read-side scheduler.
// No logic of its own; imported by the scheduler and its skid buffer.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkg;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_HDR,
        ST_LEN,
        ST_BODY,
        ST_FLUSH
    } rd_state_t;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] dat;
    } skid_ent_t;

    // Round-robin successor over the three ports.
    function automatic logic [1:0] port_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry egress buffer holding {sop, eop, data} tagged bytes.
// Latency: a pushed byte is visible on the output the following cycle.
// Backpressure: output holds while not ready; the caller's credit scheme keeps pushes within capacity.
module router_skid_buf
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_push_vld,
    input  skid_ent_t  i_push_dat,
    output logic       o_out_vld,
    input  logic       i_out_rdy,
    output skid_ent_t  o_out_dat,
    output logic [1:0] o_count
);

    skid_ent_t  r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = o_out_vld & i_out_rdy;
    assign w_push = i_push_vld & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_dat;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_out_vld = (r_count != 2'd0);
    assign o_out_dat = r_mem[r_rptr];
    assign o_count   = r_count;

endmodule

// File: rtl/router_rd_sched.sv
// Packet-granular round-robin drain of the router's three output ports onto one byte stream.
// Latency: vld_out rise to first egress byte is 3 cycles; one LEN bubble per packet, then 1 byte/cycle.
// Backpressure: m_ready low stops reads via skid credit; ROUTER_RD_PARITY_EN adds par_err checking.
module router_rd_sched
    import router_pkg::*;
#(
    parameter int STALL_LIMIT = 24
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] grant,
    output logic       abort
`ifdef ROUTER_RD_PARITY_EN
    ,
    output logic       par_err
`endif
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    rd_state_t   r_state;
    logic [1:0]  r_grant;
    logic [1:0]  r_rr_ptr;
    logic [6:0]  r_remain;
    logic [SW-1:0] r_stall_cnt;
    logic        r_inflight;
    logic        r_inflight_sop;
    logic        r_inflight_eop;
    logic        r_abort;

    rd_state_t   w_state_nxt;
    logic [1:0]  w_grant_nxt;
    logic [1:0]  w_rr_nxt;
    logic [6:0]  w_remain_nxt;
    logic [SW-1:0] w_stall_nxt;
    logic        w_abort_nxt;
    logic        w_rd;
    logic        w_rd_sop;
    logic        w_rd_eop;

    logic [2:0]  w_vld;
    logic        w_gvld;
    logic [7:0]  w_port_dat;
    logic [1:0]  w_c0, w_c1, w_c2;
    logic        w_arb_hit;
    logic [1:0]  w_arb_port;
    logic [5:0]  w_len;

    logic        w_skid_vld;
    skid_ent_t   w_head;
    skid_ent_t   w_push_ent;
    logic [1:0]  w_occ;
    logic        w_pop;
    logic [2:0]  w_level;
    logic        w_credit;

    assign w_vld = {vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        w_gvld     = 1'b0;
        w_port_dat = 8'd0;
        case (r_grant)
            2'd0: begin w_gvld = vld_out_0; w_port_dat = data_out_0; end
            2'd1: begin w_gvld = vld_out_1; w_port_dat = data_out_1; end
            2'd2: begin w_gvld = vld_out_2; w_port_dat = data_out_2; end
            default: begin w_gvld = 1'b0; w_port_dat = 8'd0; end
        endcase
    end

    assign w_c0 = r_rr_ptr;
    assign w_c1 = port_next(w_c0);
    assign w_c2 = port_next(w_c1);

    always_comb begin
        w_arb_hit  = 1'b1;
        w_arb_port = w_c0;
        if (w_vld[w_c0]) begin
            w_arb_port = w_c0;
        end else if (w_vld[w_c1]) begin
            w_arb_port = w_c1;
        end else if (w_vld[w_c2]) begin
            w_arb_port = w_c2;
        end else begin
            w_arb_hit  = 1'b0;
            w_arb_port = GRANT_NONE;
        end
    end

    // A read lands in the skid next cycle, so count it against space now.
    assign w_pop    = w_skid_vld & m_ready;
    assign w_level  = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_inflight};
    assign w_credit = (w_level < 3'd2);
    assign w_len    = w_port_dat[LEN_MSB:LEN_LSB];

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr_ptr;
        w_remain_nxt = r_remain;
        w_stall_nxt  = r_stall_cnt;
        w_abort_nxt  = 1'b0;
        w_rd         = 1'b0;
        w_rd_sop     = 1'b0;
        w_rd_eop     = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_arb_hit) begin
                    w_grant_nxt = w_arb_port;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_gvld && w_credit) begin
                    w_rd        = 1'b1;
                    w_rd_sop    = 1'b1;
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (r_inflight) begin
                    w_remain_nxt = {1'b0, w_len} + 7'd1;
                    w_stall_nxt  = '0;
                    w_state_nxt  = ST_BODY;
                end
            end
            ST_BODY: begin
                if (w_gvld) begin
                    w_stall_nxt = '0;
                    if (w_credit) begin
                        w_rd         = 1'b1;
                        w_remain_nxt = r_remain - 7'd1;
                        if (r_remain == 7'd1) begin
                            w_rd_eop    = 1'b1;
                            w_state_nxt = ST_FLUSH;
                        end
                    end
                end else if (r_stall_cnt == SW'(STALL_LIMIT - 1)) begin
                    // Abandon the packet: already-buffered bytes still drain, untagged.
                    w_abort_nxt = 1'b1;
                    w_stall_nxt = '0;
                    w_rr_nxt    = port_next(r_grant);
                    w_grant_nxt = GRANT_NONE;
                    w_state_nxt = ST_ARB;
                end else begin
                    w_stall_nxt = r_stall_cnt + SW'(1);
                end
            end
            ST_FLUSH: begin
                if (w_pop && w_head.eop) begin
                    w_rr_nxt    = port_next(r_grant);
                    w_grant_nxt = GRANT_NONE;
                    w_state_nxt = ST_ARB;
                end
            end
            default: begin
                w_grant_nxt = GRANT_NONE;
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_ARB;
            r_grant        <= GRANT_NONE;
            r_rr_ptr       <= 2'd0;
            r_remain       <= 7'd0;
            r_stall_cnt    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_sop <= 1'b0;
            r_inflight_eop <= 1'b0;
            r_abort        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_rr_ptr       <= w_rr_nxt;
            r_remain       <= w_remain_nxt;
            r_stall_cnt    <= w_stall_nxt;
            r_inflight     <= w_rd;
            r_inflight_sop <= w_rd_sop;
            r_inflight_eop <= w_rd_eop;
            r_abort        <= w_abort_nxt;
        end
    end

    assign w_push_ent.sop = r_inflight_sop;
    assign w_push_ent.eop = r_inflight_eop;
    assign w_push_ent.dat = w_port_dat;

    router_skid_buf u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .i_push_vld (r_inflight),
        .i_push_dat (w_push_ent),
        .o_out_vld  (w_skid_vld),
        .i_out_rdy  (m_ready),
        .o_out_dat  (w_head),
        .o_count    (w_occ)
    );

    assign read_enb_0 = w_rd && (r_grant == 2'd0);
    assign read_enb_1 = w_rd && (r_grant == 2'd1);
    assign read_enb_2 = w_rd && (r_grant == 2'd2);

    assign m_valid = w_skid_vld;
    assign m_data  = w_head.dat;
    assign m_sop   = w_skid_vld & w_head.sop;
    assign m_eop   = w_skid_vld & w_head.eop;
    assign grant   = r_grant;
    assign abort   = r_abort;

`ifdef ROUTER_RD_PARITY_EN
    logic [7:0] r_xor;
    logic       r_par_bad;
    logic       w_par_err;

    // Only one eop byte can sit in the skid at a time, so a single flag suffices.
    assign w_par_err = r_par_bad & m_valid & m_eop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_xor     <= 8'd0;
            r_par_bad <= 1'b0;
        end else begin
            if (r_inflight && r_inflight_sop) begin
                r_xor <= w_port_dat;
            end else if (r_inflight && !r_inflight_eop) begin
                r_xor <= r_xor ^ w_port_dat;
            end
            if (r_inflight && r_inflight_eop) begin
                r_par_bad <= (r_xor != w_port_dat);
            end else if (w_par_err) begin
                r_par_bad <= 1'b0;
            end
        end
    end

    assign par_err = w_par_err;
`endif

endmodule

// File: tb/tb_router_rd_sched.sv
// Directed bench for router_rd_sched: router port models feed bytes, a scoreboard checks the egress stream.
// Define ROUTER_RD_PARITY_EN to exercise the parity checker as well.
module tb_router_rd_sched;
    import router_pkg::*;

    localparam int STALL = 24;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
    logic [7:0] data_out_0 = 8'd0, data_out_1 = 8'd0, data_out_2 = 8'd0;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_sop, m_eop;
    logic [1:0] grant;
    logic       abort;
`ifdef ROUTER_RD_PARITY_EN
    logic       par_err;
`endif

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       bad;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pq0[$], pq1[$], pq2[$];
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0, eop_cnt = 0, abort_cnt = 0, par_cnt = 0;
    int rd_cnt[3];

    router_rd_sched #(.STALL_LIMIT(STALL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .vld_out_0  (vld_out_0),
        .vld_out_1  (vld_out_1),
        .vld_out_2  (vld_out_2),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .read_enb_0 (read_enb_0),
        .read_enb_1 (read_enb_1),
        .read_enb_2 (read_enb_2),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .grant      (grant),
        .abort      (abort)
`ifdef ROUTER_RD_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int p, input logic [7:0] b);
        case (p)
            0: pq0.push_back(b);
            1: pq1.push_back(b);
            default: pq2.push_back(b);
        endcase
    endtask

    task automatic push_exp(input logic sop, input logic eop, input logic bad, input logic [7:0] d);
        exp_t e;
        e.sop = sop;
        e.eop = eop;
        e.bad = bad;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input int p, input int len, input bit corrupt);
        logic [7:0] hdr, b, par;
        hdr = 8'd0;
        hdr[LEN_MSB:LEN_LSB] = len[5:0];
        hdr[ADDR_MSB:0]      = p[1:0];
        par = hdr;
        push_byte(p, hdr);
        push_exp(1'b1, 1'b0, 1'b0, hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par = par ^ b;
            push_byte(p, b);
            push_exp(1'b0, 1'b0, 1'b0, b);
        end
        if (corrupt) par = par ^ 8'h5A;
        push_byte(p, par);
        push_exp(1'b0, 1'b1, corrupt, par);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant != GRANT_NONE) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_grant"}, {30'd0, grant}, {30'd0, GRANT_NONE});
    endtask

    // Router output port model: data appears the cycle after read_enb.
    always @(posedge clk) begin
        if (read_enb_0) begin
            if (pq0.size() > 0) data_out_0 <= pq0.pop_front();
            else chk("read_empty_p0", 32'(pq0.size()), 32'd1);
        end
        if (read_enb_1) begin
            if (pq1.size() > 0) data_out_1 <= pq1.pop_front();
            else chk("read_empty_p1", 32'(pq1.size()), 32'd1);
        end
        if (read_enb_2) begin
            if (pq2.size() > 0) data_out_2 <= pq2.pop_front();
            else chk("read_empty_p2", 32'(pq2.size()), 32'd1);
        end
        vld_out_0 <= (pq0.size() > 0);
        vld_out_1 <= (pq1.size() > 0);
        vld_out_2 <= (pq2.size() > 0);
    end

    // Egress scoreboard and per-cycle read-enable rules.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("egress_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("egress_byte", {22'd0, m_sop, m_eop, m_data}, {22'd0, e.sop, e.eop, e.dat});
`ifdef ROUTER_RD_PARITY_EN
                    chk("par_err_on_byte", {31'd0, par_err}, {31'd0, e.bad & e.eop});
`endif
                    acc_cnt++;
                    if (m_eop) eop_cnt++;
                end
            end
`ifdef ROUTER_RD_PARITY_EN
            if (par_err) par_cnt++;
`endif
            chk("read_enb_onehot", {31'd0, $onehot0({read_enb_2, read_enb_1, read_enb_0})}, 32'd1);
            chk("read_enb_needs_vld",
                {29'd0, {read_enb_2, read_enb_1, read_enb_0} & ~{vld_out_2, vld_out_1, vld_out_0}}, 32'd0);
            if (read_enb_0) rd_cnt[0]++;
            if (read_enb_1) rd_cnt[1]++;
            if (read_enb_2) rd_cnt[2]++;
            if (abort) abort_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, base, eop_base, abort_base;
        logic [9:0] held;

        rd_cnt[0] = 0; rd_cnt[1] = 0; rd_cnt[2] = 0;
        repeat (3) @(negedge clk);
        chk("rst_read_enb", {29'd0, read_enb_2, read_enb_1, read_enb_0}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_sop", {31'd0, m_sop}, 32'd0);
        chk("rst_m_eop", {31'd0, m_eop}, 32'd0);
        chk("rst_abort", {31'd0, abort}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd3);
`ifdef ROUTER_RD_PARITY_EN
        chk("rst_par_err", {31'd0, par_err}, 32'd0);
`endif
        @(posedge clk); #1;
        resetn = 1'b1;

        // len = 3 on port 1, header 0x0D, with first-byte latency
        @(posedge clk); #1;
        rd_cnt[1] = 0;
        send_pkt(1, 3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t0_read_enb_1", {31'd0, read_enb_1}, 32'd0);
        chk("t0_grant", {30'd0, grant}, 32'd3);
        @(negedge clk);
        chk("t1_read_enb_1", {31'd0, read_enb_1}, 32'd1);
        chk("t1_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        chk("t2_m_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        chk("t3_m_valid", {31'd0, m_valid}, 32'd1);
        chk("t3_m_sop", {31'd0, m_sop}, 32'd1);
        chk("t3_hdr", {24'd0, m_data}, 32'h0D);
        wait_idle("len3");
        chk("len3_read_cycles", 32'(rd_cnt[1]), 32'd5);
        chk("len3_eops", 32'(eop_cnt), 32'd1);

        // len = 0 on port 2: two bytes, sop and eop on separate bytes
        @(posedge clk); #1;
        base = acc_cnt;
        eop_base = eop_cnt;
        send_pkt(2, 0, 1'b0);
        wait_idle("len0");
        chk("len0_bytes", 32'(acc_cnt - base), 32'd2);
        chk("len0_eops", 32'(eop_cnt - eop_base), 32'd1);

        // ports 0 and 2 together, port 0 holding a second packet behind the first
        @(posedge clk); #1;
        send_pkt(0, 2, 1'b0);
        send_pkt(2, 2, 1'b0);
        send_pkt(0, 2, 1'b0);
        wait_idle("rr_fair");

        // m_ready low for 6 cycles in the middle of a len = 5 packet
        @(posedge clk); #1;
        base = acc_cnt;
        send_pkt(1, 5, 1'b0);
        n = 0;
        while (acc_cnt < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reached", 32'(acc_cnt - base), 32'd2);
        @(posedge clk); #1;
        m_ready = 1'b0;
        held = 10'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) held = {m_sop, m_eop, m_data};
            else chk("bp_hold_stable", {22'd0, m_sop, m_eop, m_data}, {22'd0, held});
            if (i >= 2) begin
                chk("bp_no_read", {29'd0, read_enb_2, read_enb_1, read_enb_0}, 32'd0);
                chk("bp_valid", {31'd0, m_valid}, 32'd1);
            end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle("bp");
        chk("bp_bytes", 32'(acc_cnt - base), 32'd7);

        // port 0 stalls after one payload byte of a len = 3 packet
        @(posedge clk); #1;
        eop_base = eop_cnt;
        abort_base = abort_cnt;
        push_byte(0, 8'h0C);
        push_byte(0, 8'h55);
        push_exp(1'b1, 1'b0, 1'b0, 8'h0C);
        push_exp(1'b0, 1'b0, 1'b0, 8'h55);
        n = 0;
        while (!(grant == 2'd0 && vld_out_0 == 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("stall_started", {30'd0, grant}, 32'd0);
        repeat (STALL - 2) @(negedge clk);
        chk("stall_no_early_abort", 32'(abort_cnt - abort_base), 32'd0);
        repeat (4) @(negedge clk);
        chk("stall_abort_once", 32'(abort_cnt - abort_base), 32'd1);
        chk("stall_grant_none", {30'd0, grant}, 32'd3);
        chk("stall_no_eop", 32'(eop_cnt - eop_base), 32'd0);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        send_pkt(0, 1, 1'b0);
        wait_idle("after_abort");
        chk("after_abort_eop", 32'(eop_cnt - eop_base), 32'd1);
        chk("after_abort_no_more_abort", 32'(abort_cnt - abort_base), 32'd1);

`ifdef ROUTER_RD_PARITY_EN
        // corrupted parity on a len = 4 packet, then a clean one
        @(posedge clk); #1;
        base = par_cnt;
        send_pkt(1, 4, 1'b1);
        wait_idle("par_bad");
        chk("par_bad_pulses", 32'(par_cnt - base), 32'd1);
        @(posedge clk); #1;
        send_pkt(2, 4, 1'b0);
        wait_idle("par_good");
        chk("par_good_pulses", 32'(par_cnt - base), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
